// File: rtl/dram_slot_arb_pkg.sv
// dram_slot_arb_pkg: shared owner encoding, byte-enable codes and address width
package dram_slot_arb_pkg;
  localparam int ADDR_W = 21;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA} owner_e;
  localparam logic [1:0] BSEL_LO = 2'b01;
  localparam logic [1:0] BSEL_HI = 2'b10;
  localparam logic [1:0] BSEL_W  = 2'b11;
endpackage

// File: rtl/dram_slot_arb.sv
// dram_slot_arb: 4-phase DRAM slot arbiter between video, Z80 and DMA with CPU handshake
module dram_slot_arb
  import dram_slot_arb_pkg::*;
#(
  parameter int DMA_MAXWAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0,
  input  logic              c1,
  input  logic              c2,
  input  logic              c3,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_strobe,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wrbsel,
  input  logic [7:0]        cpu_wrdata,
  output logic              cpu_next,
  output logic              cpu_strobe,
  output logic              cpu_latch,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [15:0]       dma_wrdata,
  output logic              dma_next,
  output logic              dma_strobe,
  output logic              dram_req,
  output logic              dram_rnw,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [1:0]        dram_bsel,
  output logic [15:0]       dram_wrdata
);
  owner_e owner_q, owner_d, grant;
  logic [1:0] starve_q, starve_d;
  logic rnw_q, rnw_d, chain_q, chain_d, dma_force, cpu_rd;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] bsel_q, bsel_d;
  logic [15:0] wrdata_q, wrdata_d;
  assign dma_force = dma_req && starve_q == 2'(DMA_MAXWAIT);
  assign cpu_next  = !vid_req && !dma_force;
  assign grant = vid_req ? OWN_VID : dma_force ? OWN_DMA : cpu_req ? OWN_CPU : dma_req ? OWN_DMA : OWN_NONE;
  assign cpu_rd = owner_q == OWN_CPU && rnw_q;
  always_comb begin
    owner_d  = owner_q;
    starve_d = starve_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    bsel_d   = bsel_q;
    wrdata_d = wrdata_q;
    chain_d  = chain_q;
    if (c3) begin
      owner_d  = grant;
      chain_d  = cpu_rd;
      starve_d = (grant == OWN_DMA || !dma_req) ? 2'd0 :
                 grant == OWN_CPU ? (starve_q == 2'd3 ? starve_q : starve_q + 2'd1) : starve_q;
      if (grant == OWN_VID) begin
        rnw_d  = 1'b1;
        addr_d = vid_addr;
        bsel_d = BSEL_W;
      end
      if (grant == OWN_CPU) begin
        rnw_d    = cpu_rnw;
        addr_d   = cpu_addr;
        bsel_d   = cpu_rnw ? BSEL_W : cpu_wrbsel ? BSEL_HI : BSEL_LO;
        wrdata_d = {cpu_wrdata, cpu_wrdata};
      end
      if (grant == OWN_DMA) begin
        rnw_d    = dma_rnw;
        addr_d   = dma_addr;
        bsel_d   = BSEL_W;
        wrdata_d = dma_wrdata;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= 2'd0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      bsel_q   <= 2'b00;
      wrdata_q <= 16'h0;
      chain_q  <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      bsel_q   <= bsel_d;
      wrdata_q <= wrdata_d;
      chain_q  <= chain_d;
    end
  end
  // chain_q bridges c0/c1 when a CPU read slot follows another CPU read slot
  assign cpu_latch   = cpu_rd && (c2 || c3 || ((c0 || c1) && chain_q));
  assign cpu_strobe  = c2 && cpu_rd;
  assign vid_strobe  = c2 && owner_q == OWN_VID;
  assign dma_strobe  = c2 && owner_q == OWN_DMA && rnw_q;
  assign dma_next    = owner_q == OWN_DMA;
  assign dram_req    = owner_q != OWN_NONE;
  assign dram_rnw    = rnw_q;
  assign dram_addr   = addr_q;
  assign dram_bsel   = bsel_q;
  assign dram_wrdata = wrdata_q;
endmodule

// File: tb/tb_dram_slot_arb.sv
// tb_dram_slot_arb: directed checks of slot arbitration, handshake and reset abort
module tb_dram_slot_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ph = 2'd0;
  logic c0, c1, c2, c3;
  logic vid_req, cpu_req, cpu_rnw, cpu_wrbsel, dma_req, dma_rnw;
  logic [20:0] vid_addr, cpu_addr, dma_addr;
  logic [7:0] cpu_wrdata;
  logic [15:0] dma_wrdata;
  logic vid_strobe, cpu_next, cpu_strobe, cpu_latch, dma_next, dma_strobe;
  logic dram_req, dram_rnw;
  logic [20:0] dram_addr;
  logic [1:0] dram_bsel;
  logic [15:0] dram_wrdata;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  assign c0 = ph == 2'd0;
  assign c1 = ph == 2'd1;
  assign c2 = ph == 2'd2;
  assign c3 = ph == 2'd3;
  dram_slot_arb dut (
    .clk(clk), .rst(rst), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_strobe(vid_strobe),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wrbsel(cpu_wrbsel),
    .cpu_wrdata(cpu_wrdata), .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wrdata(dma_wrdata),
    .dma_next(dma_next), .dma_strobe(dma_strobe),
    .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr), .dram_bsel(dram_bsel),
    .dram_wrdata(dram_wrdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step_to(input logic [1:0] p);
    @(negedge clk);
    while (ph != p) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    {vid_req, cpu_req, cpu_rnw, cpu_wrbsel, dma_req, dma_rnw} = '0;
    vid_addr = '0; cpu_addr = '0; dma_addr = '0; cpu_wrdata = '0; dma_wrdata = '0;
    repeat (3) @(negedge clk);
    chk("rst dram_req", dram_req, 0);
    chk("rst dram_rnw", dram_rnw, 0);
    chk("rst dram_addr", dram_addr, 0);
    chk("rst dram_bsel", dram_bsel, 0);
    chk("rst dram_wrdata", dram_wrdata, 0);
    chk("rst strobes", {vid_strobe, cpu_strobe, dma_strobe}, 0);
    chk("rst cpu_latch", cpu_latch, 0);
    chk("rst dma_next", dma_next, 0);
    chk("rst cpu_next", cpu_next, 1);
    rst = 1'b0;
    // single CPU read
    step_to(0);
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h0ABCD;
    step_to(3);
    chk("rd cpu_next", cpu_next, 1);
    chk("rd idle dram_req", dram_req, 0);
    step_to(0);
    chk("rd dram_req", dram_req, 1);
    chk("rd dram_addr", dram_addr, 21'h0ABCD);
    chk("rd dram_bsel", dram_bsel, 2'b11);
    chk("rd dram_rnw", dram_rnw, 1);
    chk("rd latch c0", cpu_latch, 0);
    cpu_req = 0;
    step_to(2);
    chk("rd cpu_strobe c2", cpu_strobe, 1);
    chk("rd latch c2", cpu_latch, 1);
    chk("rd vid_strobe c2", vid_strobe, 0);
    step_to(3);
    chk("rd cpu_strobe c3", cpu_strobe, 0);
    chk("rd latch c3", cpu_latch, 1);
    step_to(0);
    chk("idle dram_req", dram_req, 0);
    chk("idle latch", cpu_latch, 0);
    chk("idle addr hold", dram_addr, 21'h0ABCD);
    // CPU write, high byte
    cpu_req = 1; cpu_rnw = 0; cpu_wrbsel = 1; cpu_wrdata = 8'h5A; cpu_addr = 21'h00123;
    step_to(0);
    chk("wr dram_req", dram_req, 1);
    chk("wr dram_rnw", dram_rnw, 0);
    chk("wr dram_bsel", dram_bsel, 2'b10);
    chk("wr dram_wrdata", dram_wrdata, 16'h5A5A);
    chk("wr dram_addr", dram_addr, 21'h00123);
    cpu_req = 0;
    step_to(2);
    chk("wr cpu_strobe", cpu_strobe, 0);
    chk("wr latch", cpu_latch, 0);
    // back-to-back CPU reads
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h0ABCD;
    step_to(0);
    chk("b2b A latch c0", cpu_latch, 0);
    step_to(2);
    chk("b2b A latch c2", cpu_latch, 1);
    step_to(0);
    chk("b2b B latch c0", cpu_latch, 1);
    chk("b2b B dram_req", dram_req, 1);
    step_to(1);
    chk("b2b B latch c1", cpu_latch, 1);
    cpu_req = 0;
    step_to(2);
    chk("b2b B latch c2", cpu_latch, 1);
    chk("b2b B cpu_strobe", cpu_strobe, 1);
    step_to(0);
    chk("b2b end latch", cpu_latch, 0);
    chk("b2b end dram_req", dram_req, 0);
    // CPU vs DMA contention: CPU,CPU,CPU,DMA repeating
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h01111;
    dma_req = 1; dma_rnw = 0; dma_addr = 21'h1F000; dma_wrdata = 16'hBEEF;
    for (int k = 0; k < 11; k++) begin
      step_to(3);
      chk($sformatf("cont%0d cpu_next", k), cpu_next, (k % 4) != 3);
      step_to(0);
      chk($sformatf("cont%0d dma_next", k), dma_next, (k % 4) == 3);
      chk($sformatf("cont%0d dram_addr", k), dram_addr, (k % 4) == 3 ? 21'h1F000 : 21'h01111);
    end
    // video with saturated starvation: video wins, DMA forced afterwards
    vid_req = 1; vid_addr = 21'h00777;
    for (int j = 0; j < 2; j++) begin
      step_to(3);
      chk($sformatf("vid%0d cpu_next", j), cpu_next, 0);
      step_to(0);
      chk($sformatf("vid%0d dram_addr", j), dram_addr, 21'h00777);
      chk($sformatf("vid%0d dram_rnw", j), dram_rnw, 1);
      chk($sformatf("vid%0d dma_next", j), dma_next, 0);
      step_to(2);
      chk($sformatf("vid%0d strobes", j), {vid_strobe, cpu_strobe, dma_strobe}, 3'b100);
    end
    vid_req = 0;
    step_to(3);
    chk("post-vid cpu_next", cpu_next, 0);
    step_to(0);
    chk("post-vid dma_next", dma_next, 1);
    chk("post-vid dram_addr", dram_addr, 21'h1F000);
    chk("post-vid dram_bsel", dram_bsel, 2'b11);
    chk("post-vid dram_wrdata", dram_wrdata, 16'hBEEF);
    chk("post-vid dram_rnw", dram_rnw, 0);
    step_to(2);
    chk("dma wr no strobe", dma_strobe, 0);
    // DMA read aborted by reset on c1
    cpu_req = 0; dma_rnw = 1;
    step_to(0);
    chk("dmard dma_next", dma_next, 1);
    chk("dmard dram_rnw", dram_rnw, 1);
    step_to(1);
    rst = 1;
    step_to(2);
    chk("abort dram_req", dram_req, 0);
    chk("abort dram_rnw", dram_rnw, 0);
    chk("abort dram_addr", dram_addr, 0);
    chk("abort dram_bsel", dram_bsel, 0);
    chk("abort dram_wrdata", dram_wrdata, 0);
    chk("abort dma_next", dma_next, 0);
    chk("abort dma_strobe", dma_strobe, 0);
    rst = 0;
    step_to(3);
    chk("resume pre-grant dram_req", dram_req, 0);
    step_to(0);
    chk("resume dma_next", dma_next, 1);
    chk("resume dram_req", dram_req, 1);
    chk("resume dram_addr", dram_addr, 21'h1F000);
    step_to(2);
    chk("resume dma_strobe", dma_strobe, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dram_slot_arb.md
# dram_slot_arb

Time-slot arbiter for the shared 16-bit DRAM port. Each 4-clock DRAM cycle (phases c0..c3) is granted to one of three requesters: video fetch, Z80 memory interface, DMA. The block generates the `cpu_next` / `cpu_strobe` / `cpu_latch` handshake consumed by the Z80 memory pager/cache, and muxes address, write data and byte enables onto the DRAM controller.

## Interface
Parameters:
- `DMA_MAXWAIT`, default 3: contested slots the CPU may win over a waiting DMA before DMA is forced; legal 1..3.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `c0`,`c1`,`c2`,`c3` in 1 each: one-hot phase strobes, repeating c0→c1→c2→c3.
- `vid_req` in 1: video wants next slot (read only).
- `vid_addr` in 21: video word address.
- `vid_strobe` out 1: video read data valid.
- `cpu_req` in 1: Z80 wants next slot.
- `cpu_rnw` in 1: 1 read, 0 write.
- `cpu_addr` in 21: word address.
- `cpu_wrbsel` in 1: byte select for writes (0 low, 1 high).
- `cpu_wrdata` in 8: write byte.
- `cpu_next` out 1: CPU would win the slot if it requests at this c3.
- `cpu_strobe` out 1: CPU read data valid pulse.
- `cpu_latch` out 1: DRAM read data, not cache, is to be presented to the Z80.
- `dma_req`, `dma_rnw` in 1 each.
- `dma_addr` in 21.
- `dma_wrdata` in 16.
- `dma_next` out 1: DMA granted for the starting slot.
- `dma_strobe` out 1: DMA read data valid.
- `dram_req` out 1: slot active.
- `dram_rnw` out 1.
- `dram_addr` out 21.
- `dram_bsel` out 2: byte enables, bit0 = low byte.
- `dram_wrdata` out 16.

## Operation
- Owner register holds one of NONE, VID, CPU, DMA. It is updated only on c3 and takes effect for the slot starting at the following c0.
- Priority at c3:
  - VID if `vid_req`.
  - Else DMA if `dma_req` and `starve == DMA_MAXWAIT`.
  - Else CPU if `cpu_req`.
  - Else DMA if `dma_req`.
  - Else NONE.
- Starvation counter `starve` (2 bits):
  - Clears when DMA is granted or when `dma_req` = 0 at c3.
  - Increments, saturating, when CPU is granted while `dma_req` = 1.
  - Video grants leave it unchanged.
- `cpu_next` is combinational, driven every cycle: `!vid_req && !(dma_req && starve == DMA_MAXWAIT)`. Consumers sample it on c3 only.
- Request signals (`*_rnw`, `*_addr`, `*_wrdata`, `cpu_wrbsel`) are registered at the c3 grant and held for the whole slot.
- DRAM outputs for the slot are driven from these registers:
  - VID: rnw = 1, bsel = 11.
  - DMA: bsel = 11, data = `dma_wrdata`.
  - CPU read: bsel = 11.
  - CPU write: bsel = 01 if `cpu_wrbsel` = 0, else 10; data = `{cpu_wrdata, cpu_wrdata}`.
  - NONE: `dram_req` = 0; other DRAM outputs hold their last values.
- `dma_next` = 1 for the 4 clocks of a DMA slot.

## Timing
- Reset values: owner = NONE, `starve` = 0. `dram_req`, `dram_rnw`, `dram_bsel`, all strobes, `cpu_latch` and `dma_next` = 0. `dram_addr` and `dram_wrdata` = 0.
- Reset mid-slot: all outputs are at reset value on the clock after `rst`. The aborted slot produces no strobe. Arbitration resumes at the first c3 after `rst` deasserts.
- Grant latency: request sampled at c3 of slot N; DRAM outputs valid from c0 of slot N+1.
- Read strobe: `cpu_strobe`, `vid_strobe` or `dma_strobe` is a 1-clock pulse on c2 of the owning read slot.
- `cpu_latch`:
  - Sets on c2 of a CPU read slot and stays 1 through c3.
  - Clears on the next c0 unless the next slot is also a CPU read. Then it stays 1 until that slot's c1 and rises again at its c2.
- Writes produce no strobe; the write slot is complete at c3.
- Simultaneous VID + CPU + DMA at saturated starvation: VID wins, `starve` holds, and DMA wins the next uncontested-by-video slot.
- `cpu_req` deasserted before c3 loses the slot. There is no pending state inside this block.

## Structure
- Shared package holds:
  - Owner enum `OWN_NONE`/`OWN_VID`/`OWN_CPU`/`OWN_DMA` (2 bits).
  - `BSEL_LO`, `BSEL_HI`, `BSEL_W`.
  - Address width constant 21.
- Single module; no sub-module required. Owner select, `starve` and output registers live inline.

## Test plan
- Only `cpu_req`=1 with `cpu_rnw`=1 and addr 0x0ABCD, from reset → `dram_req`=1 with `dram_addr`=0x0ABCD and bsel=11 from the next c0; `cpu_strobe` on c2; `cpu_latch` 1 on c2–c3.
- CPU write, `cpu_wrbsel`=1, data 0x5A → bsel=10, `dram_wrdata`=0x5A5A, `dram_rnw`=0, no `cpu_strobe`.
- `cpu_req` and `dma_req` held continuously, `DMA_MAXWAIT`=3 → grant order CPU,CPU,CPU,DMA repeating; `cpu_next`=0 at the c3 before each DMA slot.
- `vid_req` every slot plus `cpu_req` → `cpu_next`=0, only `vid_strobe` pulses, `starve` unchanged.
- Back-to-back CPU reads → `cpu_latch` stays high across the c0–c1 boundary between them.
- `rst` asserted on c1 of a DMA read slot → no `dma_strobe`; all outputs 0 next clock; the first grant follows the first c3 after release.
